// File: rtl/mux32_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mux32_arbiter_pkg
// Shared definitions for the two-requester arbiter:
//   WIDTH_DEFAULT : default payload width
//   SRC_A / SRC_B : source / grant encodings (0 = A, 1 = B)
//   state_e       : output-register FSM states (EMPTY / FULL)
// -----------------------------------------------------------------------------
package mux32_arbiter_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage : mux32_arbiter_pkg

// File: rtl/mux32_arbiter_mux.sv
// -----------------------------------------------------------------------------
// Mux32Bit2To1
// Plain 2:1 data multiplexer.
// Ports:
//   in0 [WIDTH] : first input, selected when op = 0
//   in1 [WIDTH] : second input, selected when op = 1
//   op          : select
//   out [WIDTH] : selected data
// -----------------------------------------------------------------------------
module Mux32Bit2To1 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             op,
  output logic [WIDTH-1:0] out
);

  // Select between the two inputs.
  always_comb begin
    out = in0;
    if (op == 1'b1) begin
      out = in1;
    end else begin
      out = in0;
    end
  end

endmodule : Mux32Bit2To1

// File: rtl/mux32_arbiter.sv
// -----------------------------------------------------------------------------
// mux32_arbiter
// Round-robin arbiter between two valid/ready requesters feeding a single
// registered output slot (EMPTY/FULL FSM). A "lock" input keeps re-granting
// the last winner while both requesters contend.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   a_data/a_valid/a_ready     : requester A
//   b_data/b_valid/b_ready     : requester B
//   lock                       : hold grant on last winner under contention
//   out_data/out_valid/out_src : registered output word, its valid and source
//   out_ready                  : consumer accept
// -----------------------------------------------------------------------------
module mux32_arbiter
  import mux32_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic             lock,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_src
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_src_q, out_src_d;
  logic             last_grant_q, last_grant_d;

  logic             can_accept_s;
  logic             grant_s;
  logic             grant_valid_s;
  logic [WIDTH-1:0] mux_data_s;

  Mux32Bit2To1 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .in0 (a_data),
    .in1 (b_data),
    .op  (grant_s),
    .out (mux_data_s)
  );

  // Grant selection, ready generation and next-state computation.
  always_comb begin
    can_accept_s  = 1'b0;
    grant_s       = SRC_A;
    grant_valid_s = 1'b0;
    state_d       = state_q;
    out_data_d    = out_data_q;
    out_src_d     = out_src_q;
    last_grant_d  = last_grant_q;

    // The slot can take a word if it is empty or is being drained this cycle.
    // Readies are held low while reset is asserted.
    can_accept_s = !reset && ((state_q == EMPTY) || out_ready);

    if (a_valid && b_valid) begin
      // Contention: lock re-grants the last winner, otherwise alternate.
      grant_s       = lock ? last_grant_q : ~last_grant_q;
      grant_valid_s = can_accept_s;
    end else if (a_valid) begin
      grant_s       = SRC_A;
      grant_valid_s = can_accept_s;
    end else if (b_valid) begin
      grant_s       = SRC_B;
      grant_valid_s = can_accept_s;
    end else begin
      grant_s       = last_grant_q;
      grant_valid_s = 1'b0;
    end

    if (grant_valid_s) begin
      state_d      = FULL;
      out_data_d   = mux_data_s;
      out_src_d    = grant_s;
      last_grant_d = grant_s;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end else begin
      state_d = state_q;
    end
  end

  assign a_ready = grant_valid_s && (grant_s == SRC_A);
  assign b_ready = grant_valid_s && (grant_s == SRC_B);

  // All state: FSM, output register, source and round-robin pointer.
  // last_grant resets to B so that A wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      out_data_q   <= {WIDTH{1'b0}};
      out_src_q    <= SRC_A;
      last_grant_q <= SRC_B;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule : mux32_arbiter

// File: tb/tb_mux32_arbiter.sv
module tb_mux32_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a_data, b_data, out_data;
  logic         a_valid, a_ready, b_valid, b_ready;
  logic         lock, out_valid, out_ready, out_src;

  int checks   = 0;
  int failures = 0;

  // behavioural reference: one output slot plus round-robin pointer
  logic         m_full;
  logic [W-1:0] m_data;
  logic         m_src;
  logic         m_last;
  logic         obs_a, obs_b;

  mux32_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_data    (a_data),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .b_data    (b_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .lock      (lock),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check at negedge, advance the model.
  task automatic step(input logic rst, input logic av, input logic [W-1:0] ad,
                      input logic bv, input logic [W-1:0] bd,
                      input logic lk, input logic ordy);
    logic want, who;
    reset = rst; a_valid = av; a_data = ad; b_valid = bv; b_data = bd;
    lock = lk; out_ready = ordy;
    @(negedge clk);
    want = 1'b0; who = 1'b0;
    if (!rst && (!m_full || ordy)) begin
      if (av && bv) begin want = 1'b1; who = lk ? m_last : !m_last; end
      else if (av) begin want = 1'b1; who = 1'b0; end
      else if (bv) begin want = 1'b1; who = 1'b1; end
    end
    check_eq("a_ready", a_ready, want && !who);
    check_eq("b_ready", b_ready, want && who);
    check_eq("out_valid", out_valid, m_full);
    check_eq("out_data", out_data, m_data);
    check_eq("out_src", out_src, m_src);
    obs_a = a_ready; obs_b = b_ready;
    if (rst) begin
      m_full = 1'b0; m_data = '0; m_src = 1'b0; m_last = 1'b1;
    end else if (want) begin
      m_full = 1'b1; m_data = who ? bd : ad; m_src = who; m_last = who;
    end else if (m_full && ordy) begin
      m_full = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  localparam logic [W-1:0] DA = 32'h00000043;
  localparam logic [W-1:0] DB = 32'h8000007F;

  initial begin
    m_full = 1'b0; m_data = '0; m_src = 1'b0; m_last = 1'b1;
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    lock = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    step(1'b1, 1'b1, DA, 1'b1, DB, 1'b0, 1'b1);
    check_eq("rst_ready_a", obs_a, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_data", out_data, 32'h0);

    // A only
    step(1'b0, 1'b1, DA, 1'b0, DB, 1'b0, 1'b1);
    check_eq("aonly_ready", obs_a, 1'b1);
    check_eq("aonly_data", out_data, DA);
    check_eq("aonly_src", out_src, 1'b0);
    check_eq("aonly_valid", out_valid, 1'b1);

    // contention after reset: A,B,A,B
    step(1'b1, 1'b0, DA, 1'b0, DB, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, DA, 1'b1, DB, 1'b0, 1'b1);
      check_eq("rr_src", out_src, (i % 2 == 1) ? 1'b1 : 1'b0);
    end

    // backpressure with B word held
    check_eq("bp_start", out_data, DB);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, DA, 1'b0, DB, 1'b0, 1'b0);
      check_eq("bp_ready", obs_a, 1'b0);
      check_eq("bp_hold", out_data, DB);
    end
    step(1'b0, 1'b1, DA, 1'b0, DB, 1'b0, 1'b1);
    check_eq("bp_accept", obs_a, 1'b1);
    check_eq("bp_next", out_data, DA);

    // lock: B grant, then 3 locked B grants, then A
    step(1'b0, 1'b1, DA, 1'b1, DB, 1'b0, 1'b1);
    check_eq("lk_first", out_src, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, DA, 1'b1, DB, 1'b1, 1'b1);
      check_eq("lk_hold", out_src, 1'b1);
    end
    step(1'b0, 1'b1, DA, 1'b1, DB, 1'b0, 1'b1);
    check_eq("lk_release", out_src, 1'b0);

    // drain
    step(1'b0, 1'b0, DA, 1'b0, DB, 1'b0, 1'b1);
    check_eq("drain_valid", out_valid, 1'b0);

    // mid-operation reset
    step(1'b0, 1'b0, DA, 1'b1, DB, 1'b0, 1'b0);
    check_eq("mr_full", out_data, DB);
    step(1'b1, 1'b1, DA, 1'b1, DB, 1'b0, 1'b0);
    check_eq("mr_valid", out_valid, 1'b0);
    check_eq("mr_data", out_data, 32'h0);
    step(1'b0, 1'b1, DA, 1'b1, DB, 1'b0, 1'b1);
    check_eq("mr_first", out_src, 1'b0);

    // random traffic against the model
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 40) == 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)), W'($urandom),
           1'($urandom_range(0, 1)), W'($urandom),
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mux32_arbiter

// File: doc/mux32_arbiter.md
MUX32_ARBITER -- requirements
Module: mux32_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: datapath width of all data ports.
REQ-002 Port clk  input  1: sole clock; all state updates on its rising edge.
REQ-003 Port reset  input  1: synchronous, active-high reset.
REQ-004 Port a_data  input  WIDTH: requester A payload.
REQ-005 Port a_valid  input  1: requester A has data.
REQ-006 Port a_ready  output  1: requester A payload accepted this cycle.
REQ-007 Port b_data  input  WIDTH: requester B payload.
REQ-008 Port b_valid  input  1: requester B has data.
REQ-009 Port b_ready  output  1: requester B payload accepted this cycle.
REQ-010 Port lock  input  1: keep the grant on the last-granted requester while it stays valid.
REQ-011 Port out_data  output  WIDTH: registered selected payload.
REQ-012 Port out_valid  output  1: out_data holds an unconsumed word.
REQ-013 Port out_ready  input  1: consumer accepts out_data this cycle.
REQ-014 Port out_src  output  1: source of the current out_data (0 = A, 1 = B).

Function
REQ-015 The block SHALL use a two-state FSM: EMPTY (output register empty) and FULL (output register holds a word).
REQ-016 A can_accept condition SHALL be true in EMPTY, or in FULL when out_ready=1.
REQ-017 When can_accept=1 and exactly one requester is valid, that requester SHALL be granted.
REQ-018 When can_accept=1 and both requesters are valid, the requester other than last_grant SHALL be granted (round-robin), unless lock=1, in which case last_grant SHALL be granted again.
REQ-019 The data selection SHALL be a 2:1 mux with select = grant (0 picks a_data, 1 picks b_data).
REQ-020 a_ready/b_ready SHALL be combinational, one-hot or zero, and asserted only for the granted requester in a cycle where can_accept=1.
REQ-021 On a grant, out_data, out_src and last_grant SHALL load on the same edge, and the FSM SHALL go to or stay in FULL; latency from acceptance to out_valid=1 SHALL be one cycle.
REQ-022 In FULL with out_ready=1 and no valid requester, the FSM SHALL return to EMPTY and out_valid SHALL deassert on the next cycle.
REQ-023 In FULL with out_ready=0, out_data/out_src SHALL hold, and both ready outputs SHALL be 0.
REQ-024 Simultaneous consume and accept SHALL sustain one word per cycle with no bubble.
REQ-025 out_valid SHALL equal (state == FULL).
REQ-026 Input valid dropping without a handshake SHALL have no effect on state.

Reset
REQ-027 While reset=1 on a clock edge, the state SHALL become EMPTY, out_valid 0, out_data 0, out_src 0, and last_grant 1 (B), so A wins the first contention.
REQ-028 Reset asserted mid-transfer SHALL discard any held word; a_ready/b_ready SHALL be 0 during reset.

Structure
REQ-029 A shared package SHALL hold the WIDTH default, the source encodings SRC_A=0/SRC_B=1, and the FSM state encodings EMPTY/FULL.
REQ-030 The data selection SHALL instantiate the existing 32-bit 2:1 mux (Mux32Bit2To1, op=0 selects first input) as the sole sub-module.
REQ-031 All sequential logic SHALL reside in one clocked process and all grant logic in one combinational process.

Verification
REQ-032 Reset, then A only: a_data=32'h00000043, a_valid=1 for one cycle, out_ready=1 -> a_ready=1 that cycle; next cycle out_valid=1, out_data=32'h00000043, out_src=0.
REQ-033 Contention: both valid (a=32'h00000043, b=32'h8000007F), lock=0, out_ready=1 for 4 cycles -> outputs alternate A,B,A,B, starting with A.
REQ-034 Backpressure: FULL with out_data=32'h8000007F, out_ready=0 for 3 cycles, A valid -> a_ready=0 and out_data stable; on out_ready=1, A is accepted the same cycle, and the next word is A.
REQ-035 Lock: both valid, lock=1 after a B grant -> B granted on 3 consecutive cycles; lock=0 -> next grant is A.
REQ-036 Drain: FULL, out_ready=1, no valid inputs -> out_valid=0 next cycle; FSM is EMPTY.
REQ-037 Mid-operation reset: FULL with b word, reset=1 for one cycle -> out_valid=0, out_data=0; both valid afterwards -> A granted first.
